fta_iodec64: RTL and testbench

FTA_IODEC64 -- requirements
Module: fta_iodec64

---
 rtl/fta_bus_pkg.sv | 41 ++++
 rtl/fta_iodec_pkg.sv | 39 +++
 rtl/fta_iodec_match.sv | 42 ++++
 rtl/fta_iodec64.sv | 125 ++++++++++++
 tb/tb_fta_iodec64.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fta_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fta_bus_pkg                                               |
// | Brief    : FTA 64-bit command bus request/response types and codes   |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fta_bus_pkg;

   // Cycle type indicators
   localparam logic [2:0] CLASSIC = 3'd0;
   localparam logic [2:0] ERC     = 3'd7;   // write that expects an ack

   // Response error codes
   localparam logic [2:0] OKAY    = 3'd0;
   localparam logic [2:0] DECERR  = 3'd1;   // no slave decoded the address
   localparam logic [2:0] SLVERR  = 3'd2;   // slave did not answer in time

   typedef struct packed {
      logic        cyc;
      logic        we;
      logic [2:0]  cti;
      logic [3:0]  cid;
      logic [7:0]  tid;
      logic [7:0]  sel;
      logic [31:0] padr;
      logic [63:0] dat;
   } fta_cmd_request64_t;

   typedef struct packed {
      logic        ack;
      logic        rty;
      logic [2:0]  err;
      logic [2:0]  pri;
      logic [3:0]  cid;
      logic [7:0]  tid;
      logic [31:0] adr;
      logic [63:0] dat;
   } fta_cmd_response64_t;

endpackage
`default_nettype wire

// File: rtl/fta_iodec_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fta_iodec_pkg                                             |
// | Brief    : I/O decoder state type, default address map, helpers      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package fta_iodec_pkg;
   import fta_bus_pkg::*;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } iodec_state_t;

   // Default map: eight 64 KiB windows starting at 0xFEE0_0000 (entry 0 rightmost)
   localparam logic [7:0][31:0] DEF_BASE = {
      32'hFEE7_0000, 32'hFEE6_0000, 32'hFEE5_0000, 32'hFEE4_0000,
      32'hFEE3_0000, 32'hFEE2_0000, 32'hFEE1_0000, 32'hFEE0_0000
   };
   localparam logic [7:0][31:0] DEF_MASK = {8{32'hFFFF_0000}};

   // Locally generated error response carrying the request's identity
   function automatic fta_cmd_response64_t iodec_err_resp(input fta_cmd_request64_t req,
                                                          input logic [2:0] err);
      fta_cmd_response64_t r;
      r     = '0;
      r.ack = 1'b1;
      r.err = err;
      r.pri = 3'd7;
      r.cid = req.cid;
      r.tid = req.tid;
      r.adr = req.padr;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fta_iodec_match.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fta_iodec_match                                           |
// | Brief    : Combinational address compare with lowest-index priority  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fta_iodec_match #(
   parameter int                      NDEV = 4,
   parameter int                      IW   = 2,
   parameter logic [NDEV-1:0][31:0]   BASE = '0,
   parameter logic [NDEV-1:0][31:0]   MASK = '0
) (
   input  logic [31:0]     padr_i,
   output logic            hit_o,
   output logic [NDEV-1:0] onehot_o,
   output logic [IW-1:0]   idx_o
);

   logic [NDEV-1:0] w_hit;

   generate
      for (genvar gi = 0; gi < NDEV; gi++) begin : g_cmp
         assign w_hit[gi] = ((padr_i ^ BASE[gi]) & MASK[gi]) == 32'h0;
      end
   endgenerate

   // Scan from the top so the lowest matching index is the one that sticks
   always_comb begin
      hit_o    = 1'b0;
      onehot_o = '0;
      idx_o    = '0;
      for (int i = NDEV - 1; i >= 0; i--) begin
         if (w_hit[i]) begin
            hit_o    = 1'b1;
            onehot_o = NDEV'(1) << i;
            idx_o    = IW'(i);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fta_iodec64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : fta_iodec64                                               |
// | Brief    : One-master to NDEV-slave I/O decoder with ack timeout     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module fta_iodec64
   import fta_bus_pkg::*;
   import fta_iodec_pkg::*;
#(
   parameter int                    NDEV = 4,
   parameter int                    TMO  = 255,
   parameter logic [NDEV-1:0][31:0] BASE = DEF_BASE[NDEV-1:0],
   parameter logic [NDEV-1:0][31:0] MASK = DEF_MASK[NDEV-1:0]
) (
   input  logic                clk,
   input  logic                rst,
   input  fta_cmd_request64_t  m_req,
   output fta_cmd_response64_t m_resp,
   output logic                busy,
   output fta_cmd_request64_t  s_req,
   output logic [NDEV-1:0]     s_cs,
   input  fta_cmd_response64_t s_resp [NDEV]
);

   localparam int IW = (NDEV > 1) ? $clog2(NDEV) : 1;
   localparam int CW = $clog2(TMO + 1);
   // Leaving WAIT on this count means the counter has just reached TMO,
   // i.e. exactly TMO WAIT cycles have elapsed without a valid ack.
   localparam logic [CW-1:0] c_TMO_LAST = CW'(TMO - 1);

   iodec_state_t        state_q;
   fta_cmd_request64_t  s_req_q;
   fta_cmd_response64_t m_resp_q;
   logic [NDEV-1:0]     s_cs_q;
   logic [IW-1:0]       idx_q;
   logic                hit_q;
   logic [CW-1:0]       cnt_q;
   logic [CW-1:0]       cnt_d;

   logic                w_hit;
   logic [NDEV-1:0]     w_onehot;
   logic [IW-1:0]       w_idx;
   logic                w_ack_ok;

   // Decode the incoming address so the select is ready on the SEL cycle
   fta_iodec_match #(
      .NDEV (NDEV),
      .IW   (IW),
      .BASE (BASE),
      .MASK (MASK)
   ) u_match (
      .padr_i   (m_req.padr),
      .hit_o    (w_hit),
      .onehot_o (w_onehot),
      .idx_o    (w_idx)
   );

   assign cnt_d    = cnt_q + CW'(1);
   assign w_ack_ok = s_resp[idx_q].ack && (s_resp[idx_q].tid == s_req_q.tid);

   // Transaction FSM; every output is a register written here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         s_req_q  <= '0;
         m_resp_q <= '0;
         s_cs_q   <= '0;
         idx_q    <= '0;
         hit_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         m_resp_q <= '0;
         s_cs_q   <= '0;
         case (state_q)
            IDLE: begin
               if (m_req.cyc) begin
                  s_req_q <= m_req;
                  s_cs_q  <= w_onehot;
                  hit_q   <= w_hit;
                  idx_q   <= w_idx;
                  state_q <= SEL;
               end
            end
            SEL: begin
               cnt_q <= '0;
               if (!hit_q) begin
                  m_resp_q <= iodec_err_resp(s_req_q, DECERR);
                  state_q  <= RSP;
               end else if (s_req_q.we && (s_req_q.cti != ERC)) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               // A matching ack takes priority over expiry on the same edge
               if (w_ack_ok) begin
                  m_resp_q <= s_resp[idx_q];
                  state_q  <= IDLE;
               end else if (cnt_q == c_TMO_LAST) begin
                  m_resp_q <= iodec_err_resp(s_req_q, SLVERR);
                  cnt_q    <= cnt_d;
                  state_q  <= RSP;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            RSP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy   = (state_q != IDLE);
   assign s_req  = s_req_q;
   assign s_cs   = s_cs_q;
   assign m_resp = m_resp_q;

endmodule
`default_nettype wire

// File: tb/tb_fta_iodec64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_fta_iodec64                                            |
// | Brief    : Scoreboard bench for fta_iodec64 with randomized traffic  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_fta_iodec64;
   import fta_bus_pkg::*;

   localparam int NDEV = 4;
   localparam int TMO  = 8;
   // Slave 2 overlaps slave 1 so the priority rule is exercised
   localparam logic [NDEV-1:0][31:0] TB_BASE = {32'h8000_0000, 32'h2000_0000, 32'h2000_0000, 32'h1000_0000};
   localparam logic [NDEV-1:0][31:0] TB_MASK = {32'h8000_0000, 32'hFF00_0000, 32'hFFFF_0000, 32'hFFFF_0000};

   typedef struct {
      fta_cmd_response64_t resp;
      int                  cyc;
   } exp_t;

   logic                clk = 1'b0;
   logic                rst = 1'b0;
   fta_cmd_request64_t  m_req;
   fta_cmd_response64_t m_resp;
   logic                busy;
   fta_cmd_request64_t  s_req;
   logic [NDEV-1:0]     s_cs;
   fta_cmd_response64_t s_resp [NDEV];

   int   checks   = 0;
   int   failures = 0;
   int   cyc_n    = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   fta_iodec64 #(
      .NDEV (NDEV),
      .TMO  (TMO),
      .BASE (TB_BASE),
      .MASK (TB_MASK)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .m_req  (m_req),
      .m_resp (m_resp),
      .busy   (busy),
      .s_req  (s_req),
      .s_cs   (s_cs),
      .s_resp (s_resp)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Address map rule: first slave whose masked base equals the masked address
   function automatic int ref_dec(input logic [31:0] a);
      for (int i = 0; i < NDEV; i++)
         if ((a & TB_MASK[i]) == (TB_BASE[i] & TB_MASK[i])) return i;
      return -1;
   endfunction

   function automatic fta_cmd_response64_t ref_err(input fta_cmd_request64_t r, input logic [2:0] e);
      fta_cmd_response64_t x;
      x = '0;
      x.ack = 1'b1; x.err = e; x.pri = 3'd7;
      x.cid = r.cid; x.tid = r.tid; x.adr = r.padr;
      return x;
   endfunction

   task automatic clear_slaves();
      for (int j = 0; j < NDEV; j++) s_resp[j] = '0;
   endtask

   // Scoreboard monitor: every response the DUT presents must be the next expected one
   always @(negedge clk) begin
      if (rst && m_resp.ack) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack: got ack err=%0d tid=%h at cycle %0d, required no ack",
                     m_resp.err, m_resp.tid, cyc_n);
         end else begin
            mon_e = exp_q.pop_front();
            chk("resp_cycle", 128'(cyc_n), 128'(mon_e.cyc));
            chk("resp_body", 128'(m_resp), 128'(mon_e.resp));
         end
      end
   end

   // Pulse reset between clock edges and confirm the outputs drop immediately
   task automatic mid_reset();
      #1 rst = 1'b0;
      #1;
      chk("rst_async_cs", 128'(s_cs), 128'(0));
      chk("rst_async_busy", 128'(busy), 128'(0));
      chk("rst_async_ack", 128'(m_resp.ack), 128'(0));
      m_req = '0;
      clear_slaves();
      @(negedge clk);
      rst = 1'b1;
   endtask

   // d: WAIT cycle (1-based) carrying the good ack, 0 = never
   // bad: inject wrong-tid / unselected acks in WAIT cycle 1
   // rst_at: 0 none, 1 reset in SEL, 2 reset in WAIT cycle 2
   task automatic txn(input bit we, input logic [2:0] cti, input logic [31:0] adr,
                      input logic [63:0] dat, input int d, input bit bad, input int rst_at);
      fta_cmd_request64_t  r;
      fta_cmd_response64_t sr;
      exp_t                e;
      int                  sl;
      int                  c0;
      int                  n;
      logic [NDEV-1:0]     exp_cs;
      bit                  waits;
      r = '0;
      r.cyc = 1'b1; r.we = we; r.cti = cti; r.cid = 4'($urandom);
      r.tid = 8'($urandom); r.sel = 8'hFF; r.padr = adr; r.dat = dat;
      sl     = ref_dec(adr);
      exp_cs = (sl >= 0) ? (NDEV'(1) << sl) : '0;
      waits  = (sl >= 0) && (!we || cti == ERC);
      sr = '0;
      sr.ack = 1'b1; sr.err = OKAY; sr.pri = 3'd2; sr.cid = r.cid; sr.tid = r.tid;
      sr.adr = adr; sr.dat = {adr ^ 32'hC0DE_0000, 24'h0, r.tid};
      c0 = cyc_n;
      m_req = r;
      if (rst_at == 0) begin
         if (sl < 0) begin
            e.resp = ref_err(r, DECERR); e.cyc = c0 + 2; exp_q.push_back(e);
         end else if (waits) begin
            if (d >= 1 && d <= TMO) begin
               e.resp = sr; e.cyc = c0 + 2 + d;
            end else begin
               e.resp = ref_err(r, SLVERR); e.cyc = c0 + 2 + TMO;
            end
            exp_q.push_back(e);
         end
      end
      @(negedge clk);                       // SEL cycle
      chk("sel_cs", 128'(s_cs), 128'(exp_cs));
      chk("sel_sreq", 128'(s_req), 128'(r));
      m_req.padr = ~adr;                    // new request offered while busy
      m_req.tid  = r.tid + 8'd1;
      if (rst_at == 1) begin
         mid_reset();
         return;
      end
      @(negedge clk);                       // first cycle after SEL
      m_req = '0;
      chk("cs_one_cycle", 128'(s_cs), 128'(0));
      chk("sreq_hold", 128'(s_req), 128'(r));
      chk("busy_after_sel", 128'(busy), 128'((sl < 0) || waits));
      if (waits) begin
         for (int k = 1; k <= TMO + 1; k++) begin
            clear_slaves();
            if (k == d) begin
               s_resp[sl] = sr;
            end else if (bad && k == 1) begin
               s_resp[sl]     = sr;
               s_resp[sl].tid = r.tid ^ 8'h5A;
               s_resp[(sl + 1) % NDEV] = sr;
            end
            if (rst_at == 2 && k == 2) begin
               mid_reset();
               return;
            end
            @(negedge clk);
         end
         clear_slaves();
      end
      n = 0;
      while (busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("busy_idle", 128'(busy), 128'(0));
   endtask

   logic [31:0] ra;
   int          rt;
   int          rd;
   bit          rwe;
   bit          rbad;
   logic [2:0]  rcti;

   initial begin
      m_req = '0;
      clear_slaves();
      repeat (3) @(negedge clk);
      chk("reset_cs", 128'(s_cs), 128'(0));
      chk("reset_busy", 128'(busy), 128'(0));
      chk("reset_resp", 128'(m_resp), 128'(0));
      chk("reset_sreq", 128'(s_req), 128'(0));
      rst = 1'b1;

      // Directed cases
      txn(1'b0, CLASSIC, TB_BASE[1],    64'h0,  1,       1'b0, 0); // read slave 1, 1-cycle ack
      txn(1'b1, CLASSIC, 32'h1000_0000, 64'hA5, 0,       1'b0, 0); // posted write slave 0
      txn(1'b0, CLASSIC, 32'h3000_0000, 64'h0,  1,       1'b0, 0); // unmapped read
      txn(1'b0, CLASSIC, 32'h2012_3400, 64'h0,  0,       1'b1, 0); // timeout with bad acks
      txn(1'b0, CLASSIC, 32'h1000_0040, 64'h0,  TMO,     1'b0, 0); // ack on expiry cycle
      txn(1'b0, CLASSIC, 32'h1000_0080, 64'h0,  TMO + 1, 1'b0, 0); // ack one cycle too late
      txn(1'b1, ERC,     32'h8000_1000, 64'h1234, 3,     1'b1, 0); // ERC write, acked
      txn(1'b1, CLASSIC, 32'h3000_0000, 64'h0,  0,       1'b0, 0); // unmapped write
      txn(1'b0, CLASSIC, 32'h2000_1234, 64'h0,  1,       1'b0, 1); // reset during SEL
      txn(1'b0, CLASSIC, 32'h1000_0000, 64'h0,  0,       1'b0, 2); // reset during WAIT
      txn(1'b0, CLASSIC, 32'h2000_0010, 64'h0,  2,       1'b0, 0); // normal after reset

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         rt = $urandom_range(0, NDEV);
         ra = $urandom;
         if (rt < NDEV) ra = (TB_BASE[rt] & TB_MASK[rt]) | (ra & ~TB_MASK[rt]);
         rwe  = 1'($urandom_range(0, 1));
         rcti = ($urandom_range(0, 2) == 0) ? ERC : 3'($urandom_range(0, 6));
         rd   = $urandom_range(0, TMO + 1);
         rbad = 1'($urandom_range(0, 1));
         txn(rwe, rcti, ra, {$urandom, $urandom}, rd, rbad, 0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
